// File: rtl/pwm_fade_ctrl_if.sv
// Command and status bundle between a fade requester and pwm_fade_ctrl.
interface pwm_fade_ctrl_if #(
  parameter int unsigned RATE_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_target;
  logic [7:0]        cmd_step;
  logic [RATE_W-1:0] cmd_rate;
  logic              abort;
  logic [7:0]        duty_out;
  logic              period_sync;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_rate, abort,
    input  cmd_ready, duty_out, period_sync, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_rate, abort,
    output cmd_ready, duty_out, period_sync, busy, done
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Soft-start / fade sequencer for a pwm_driver duty input. Duty is stepped toward a
// commanded target, only at 256-clock PWM period boundaries, every (rate+1) periods.
module pwm_fade_ctrl #(
  parameter int unsigned RATE_W = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  pwm_fade_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e            r_state, w_state_d;
  logic [7:0]        r_period_cnt;
  logic [7:0]        r_duty, w_duty_d;
  logic [7:0]        r_target, w_target_d;
  logic [7:0]        r_step, w_step_d;
  logic [RATE_W-1:0] r_rate, w_rate_d;
  logic [RATE_W-1:0] r_rate_cnt, w_rate_cnt_d;
  logic              r_done, w_done_d;

  logic              w_period_tick;
  logic              w_rising;
  logic [8:0]        w_sum;
  logic [8:0]        w_diff;
  logic [7:0]        w_next_duty;

  assign w_period_tick = (r_period_cnt == 8'd255);
  assign w_rising      = (r_target > r_duty);
  // 9-bit arithmetic so the clamp sees overflow/underflow instead of a wrapped value
  assign w_sum         = {1'b0, r_duty} + {1'b0, r_step};
  assign w_diff        = {1'b0, r_duty} - {1'b0, r_step};

  assign bus.cmd_ready   = (r_state == StIdle);
  assign bus.busy        = (r_state == StRamp);
  assign bus.duty_out    = r_duty;
  assign bus.done        = r_done;
  assign bus.period_sync = (r_period_cnt == 8'd0);

  // Free-running PWM period counter, shared phase with the pwm_driver.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_period_cnt <= 8'd0;
    end else begin
      r_period_cnt <= r_period_cnt + 8'd1;
    end
  end

  // Next duty value, saturated at the target in either direction.
  always_comb begin
    w_next_duty = r_target;
    if (w_rising) begin
      if (w_sum < {1'b0, r_target}) begin
        w_next_duty = w_sum[7:0];
      end
    end else begin
      if (!w_diff[8] && (w_diff[7:0] > r_target)) begin
        w_next_duty = w_diff[7:0];
      end
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_duty     <= 8'd0;
      r_target   <= 8'd0;
      r_step     <= 8'd1;
      r_rate     <= '0;
      r_rate_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_duty     <= w_duty_d;
      r_target   <= w_target_d;
      r_step     <= w_step_d;
      r_rate     <= w_rate_d;
      r_rate_cnt <= w_rate_cnt_d;
      r_done     <= w_done_d;
    end
  end

  // Next-state logic: command accept in idle, period-paced stepping in ramp.
  always_comb begin
    w_state_d    = r_state;
    w_duty_d     = r_duty;
    w_target_d   = r_target;
    w_step_d     = r_step;
    w_rate_d     = r_rate;
    w_rate_cnt_d = r_rate_cnt;
    w_done_d     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.cmd_valid) begin
          w_target_d   = bus.cmd_target;
          w_step_d     = (bus.cmd_step == 8'd0) ? 8'd1 : bus.cmd_step;
          w_rate_d     = bus.cmd_rate;
          w_rate_cnt_d = '0;
          if (bus.cmd_target == r_duty) begin
            w_done_d = 1'b1;
          end else begin
            w_state_d = StRamp;
          end
        end
      end
      StRamp: begin
        // Abort wins over a coincident update; duty holds and no done pulse
        if (bus.abort) begin
          w_state_d = StIdle;
        end else if (w_period_tick) begin
          if (r_rate_cnt != r_rate) begin
            w_rate_cnt_d = r_rate_cnt + {{(RATE_W-1){1'b0}}, 1'b1};
          end else begin
            w_rate_cnt_d = '0;
            w_duty_d     = w_next_duty;
            if (w_next_duty == r_target) begin
              w_done_d  = 1'b1;
              w_state_d = StIdle;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: table of fade commands with a duty scoreboard,
// plus hand-written abort and mid-ramp reset sequences.
module tb_pwm_fade_ctrl;
  localparam int unsigned RateW = 16;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  pwm_fade_ctrl_if #(.RATE_W(RateW)) u_if ();

  pwm_fade_ctrl #(.RATE_W(RateW)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (u_if)
  );

  typedef struct {
    string name;
    int    target;
    int    step;
    int    rate;
    int    n_upd;
    int    final_duty;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  int   m_duty = 0;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference ramp: push every intermediate duty the DUT should present.
  task automatic push_model(input int t, input int s);
    int d;
    int ss;
    d  = m_duty;
    ss = (s == 0) ? 1 : s;
    while (d != t) begin
      if (t > d) d = (d + ss > t) ? t : d + ss;
      else       d = (d - ss < t) ? t : d - ss;
      exp_q.push_back(d);
    end
    m_duty = t;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send_cmd(input int t, input int s, input int r, input logic ab);
    int w;
    w = 0;
    while (!u_if.cmd_ready && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    check("cmd_ready before send", int'(u_if.cmd_ready), 1);
    u_if.cmd_valid  = 1'b1;
    u_if.cmd_target = 8'(t);
    u_if.cmd_step   = 8'(s);
    u_if.cmd_rate   = RateW'(r);
    u_if.abort      = ab;
    @(posedge clk_in);
    #1;
    u_if.cmd_valid = 1'b0;
    u_if.abort     = 1'b0;
  endtask

  // Watch duty changes, compare against the scoreboard and check update spacing.
  task automatic run_ramp(input string name, input int rate, input int exp_n, input int fin);
    int  prev;
    int  since;
    int  tot;
    int  n;
    int  span;
    int  limit;
    bit  done_seen;
    bit  first;
    prev      = int'(u_if.duty_out);
    since     = 0;
    tot       = 0;
    n         = 0;
    span      = (rate + 1) * 256;
    limit     = (exp_n + 2) * span + 600;
    done_seen = 1'b0;
    first     = 1'b1;
    while (!done_seen && tot < limit) begin
      @(negedge clk_in);
      since++;
      tot++;
      if (tot == 1) begin
        check({name, " busy after accept"}, int'(u_if.busy), (exp_n > 0) ? 1 : 0);
        if (exp_n > 0) check({name, " ready in ramp"}, int'(u_if.cmd_ready), 0);
      end
      if (int'(u_if.duty_out) != prev) begin
        n++;
        if (exp_q.size() == 0) check({name, " unexpected update"}, int'(u_if.duty_out), -1);
        else check({name, " duty"}, int'(u_if.duty_out), exp_q.pop_front());
        if (first) check({name, " first interval in range"},
                         int'(since > rate * 256 && since <= span), 1);
        else check({name, " update spacing"}, since, span);
        since = 0;
        first = 1'b0;
        prev  = int'(u_if.duty_out);
      end
      if (u_if.done) begin
        done_seen = 1'b1;
        check({name, " duty at done"}, int'(u_if.duty_out), fin);
        check({name, " ready at done"}, int'(u_if.cmd_ready), 1);
        if (exp_n == 0) check({name, " done latency"}, tot, 1);
      end
    end
    check({name, " done seen"}, int'(done_seen), 1);
    check({name, " update count"}, n, exp_n);
    check({name, " scoreboard empty"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk_in);
    check({name, " done one cycle"}, int'(u_if.done), 0);
    check({name, " busy after done"}, int'(u_if.busy), 0);
  endtask

  initial begin
    int  w;
    bit  poked;
    bit  held;
    bit  pulsed;

    vecs[0] = '{"ramp_up",      64,  16, 0, 4, 64};
    vecs[1] = '{"ramp_down",    10,  20, 1, 3, 10};
    vecs[2] = '{"to_250",       250, 255, 0, 1, 250};
    vecs[3] = '{"no_wrap_255",  255, 16, 0, 1, 255};
    vecs[4] = '{"down_to_3",    3,   255, 0, 1, 3};
    vecs[5] = '{"step0_as_1",   0,   0,  0, 3, 0};
    vecs[6] = '{"equal_target", 0,   5,  0, 0, 0};

    rst_in          = 1'b1;
    u_if.cmd_valid  = 1'b0;
    u_if.cmd_target = 8'd0;
    u_if.cmd_step   = 8'd0;
    u_if.cmd_rate   = '0;
    u_if.abort      = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset duty", int'(u_if.duty_out), 0);
    check("reset busy", int'(u_if.busy), 0);
    check("reset done", int'(u_if.done), 0);
    check("reset ready", int'(u_if.cmd_ready), 1);
    check("reset period_sync", int'(u_if.period_sync), 1);
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      send_cmd(vecs[i].target, vecs[i].step, vecs[i].rate, 1'b0);
      push_model(vecs[i].target, vecs[i].step);
      run_ramp(vecs[i].name, vecs[i].rate, vecs[i].n_upd, vecs[i].final_duty);
    end

    // Abort after the third update; a command offered mid-ramp must be ignored.
    send_cmd(200, 8, 0, 1'b0);
    w     = 0;
    poked = 1'b0;
    while (int'(u_if.duty_out) != 24 && w < 2000) begin
      @(negedge clk_in);
      w++;
      if (poked) begin
        u_if.cmd_valid = 1'b0;
      end else if (int'(u_if.duty_out) == 8) begin
        check("ready low in ramp", int'(u_if.cmd_ready), 0);
        u_if.cmd_valid  = 1'b1;
        u_if.cmd_target = 8'd5;
        u_if.cmd_step   = 8'd1;
        poked           = 1'b1;
      end
    end
    u_if.cmd_valid = 1'b0;
    check("abort reached duty 24", int'(u_if.duty_out), 24);
    u_if.abort = 1'b1;
    @(posedge clk_in);
    #1;
    u_if.abort = 1'b0;
    @(negedge clk_in);
    check("abort duty held", int'(u_if.duty_out), 24);
    check("abort busy", int'(u_if.busy), 0);
    check("abort no done", int'(u_if.done), 0);
    check("abort ready", int'(u_if.cmd_ready), 1);
    held   = 1'b1;
    pulsed = 1'b0;
    repeat (600) begin
      @(negedge clk_in);
      if (int'(u_if.duty_out) != 24) held = 1'b0;
      if (u_if.done) pulsed = 1'b1;
    end
    check("abort duty stays", int'(held), 1);
    check("abort never done", int'(pulsed), 0);
    m_duty = 24;

    // Reset in the middle of a ramp at duty 96.
    send_cmd(200, 24, 0, 1'b0);
    w = 0;
    while (int'(u_if.duty_out) != 96 && w < 2000) begin
      @(negedge clk_in);
      w++;
    end
    check("reached duty 96", int'(u_if.duty_out), 96);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst duty", int'(u_if.duty_out), 0);
    check("midrst busy", int'(u_if.busy), 0);
    check("midrst ready", int'(u_if.cmd_ready), 1);
    check("midrst done", int'(u_if.done), 0);
    check("midrst period_sync", int'(u_if.period_sync), 1);
    rst_in = 1'b0;
    m_duty = 0;

    // Command with abort high in idle is still accepted.
    send_cmd(40, 20, 0, 1'b1);
    push_model(40, 20);
    run_ramp("post_reset", 0, 2, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Soft-start and fade sequencer that drives the 8-bit duty_cycle input of a pwm_driver instance.
- Accepts a fade command (target duty, step size, rate) over a valid/ready handshake.
- Ramps duty_out toward the target, one step every (rate+1) 256-clock PWM periods.
- Changes duty only at PWM period boundaries, so the driver never sees a mid-period glitch.

Parameters:
RATE_W, 16, width of cmd_rate; sets the maximum number of PWM periods between steps (2^RATE_W).

Ports:
clk_in  input  1  system clock; the same clock as the pwm_driver.
rst_in  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command (IDLE only).
cmd_target  input  8  final duty, 0-255.
cmd_step  input  8  duty increment or decrement per update; 0 is treated as 1.
cmd_rate  input  RATE_W  PWM periods between updates, minus 1.
abort  input  1  stop the ramp and hold the current duty.
duty_out  output  8  registered duty value; connects to pwm_driver duty_cycle.
period_sync  output  1  high for one cycle when the internal period counter equals 0.
busy  output  1  ramp in progress.
done  output  1  one-cycle pulse when a ramp completes.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - duty_out=0, busy=0, done=0, cmd_ready=1.
  - state=IDLE, period_cnt=0, rate_cnt=0.
  - Reset mid-ramp discards the command and forces duty_out to 0 on the next edge.
- Period counter:
  - 8-bit free-running counter that wraps 255->0.
  - period_tick = (period_cnt==255), internal.
  - period_sync = (period_cnt==0), decoded from the registered counter.
- States: IDLE, RAMP.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid && cmd_ready, the block latches target, step (0 becomes 1) and rate, and clears rate_cnt.
  - If target==duty_out: stay in IDLE and pulse done on the next cycle.
  - Otherwise: go to RAMP next cycle, with busy=1 and cmd_ready=0.
  - abort has no effect in IDLE. If abort and cmd_valid are both high in IDLE, the command is accepted.
- RAMP:
  - cmd_ready=0; cmd_valid is ignored and nothing is latched.
  - On each period_tick:
    - If rate_cnt != rate: rate_cnt++.
    - Otherwise: rate_cnt<=0 and duty is updated.
  - Update arithmetic uses 9 bits:
    - Rising: duty_out <= min(duty_out+step, target). Must not wrap past 255.
    - Falling: duty_out <= max(duty_out-step, target). Must not underflow below 0.
  - When the new duty equals target, on the same edge: done<=1 (one cycle), state<=IDLE, busy<=0, cmd_ready<=1.
  - A new command can therefore be accepted on the cycle after done is visible.
- Abort:
  - abort=1 in RAMP returns the block to IDLE on the next edge.
  - duty_out holds its current value, done is not pulsed, busy<=0.
  - abort has priority over a coincident update: the update is dropped.
- Timing:
  - The first duty change occurs on the edge at the (rate+1)-th period_tick after command acceptance.
  - Update spacing is exactly (rate+1)*256 clocks.
  - Because the period counter is free-running, the first interval is partial.
- duty_out and done change only on clock edges; no combinational path exists from inputs to duty_out.

Test Plan:
1. Reset, then cmd target=64, step=16, rate=0 from duty 0 -> duty_out goes 16,32,48,64 on consecutive period_ticks 256 clocks apart. done pulses once with duty=64, and cmd_ready=1 on that same cycle.
2. From duty 64, cmd target=10, step=20, rate=1 -> duty_out goes 44, 24, 10 at 512-clock spacing. The final step clamps to 10, not 4, and done pulses.
3. From duty 250, cmd target=255, step=16 -> a single update to 255 with no wrap. Then cmd target=0, step=0 from duty 3 -> 2, 1, 0 (step treated as 1).
4. cmd target=duty_out (e.g. 0) -> no RAMP entry. done pulses the cycle after acceptance, and busy stays 0.
5. Ramp 0->200, step=8, abort asserted after the third update (duty=24) -> duty_out holds 24, busy=0, no done pulse. A cmd_valid issued during the ramp before the abort was ignored.
6. rst_in asserted mid-ramp at duty=96 -> next edge gives duty_out=0, busy=0, cmd_ready=1, period_sync high on the following cycle. A new command is accepted normally afterwards.
